// File: rtl/ivl_uvm_ovl_bus_pkg.sv
// Shared types and default sizing for the bus window arbiter.
// Imported by the round-robin picker and by the sequencing top.
package ivl_uvm_ovl_bus_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } state_e;

endpackage

// File: rtl/ivl_uvm_ovl_rr_arbiter.sv
// Combinational round-robin picker: the first requester set after the last
// winner, wrapping, gets the one-hot grant and its binary index.
module ivl_uvm_ovl_rr_arbiter
    import ivl_uvm_ovl_bus_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_any
);

    int   cand;
    logic found;

    // Search offsets 1..NUM_REQ so the last winner is considered last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_idx) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found         = 1'b1;
                win_oh[cand]  = 1'b1;
                win_idx       = IDX_W'(cand);
            end
        end
    end

    assign win_any = |req;

endmodule

// File: rtl/ivl_uvm_ovl_bus_window_arbiter.sv
// Round-robin write-bus sequencer: grants one requester, pulses write for one
// cycle, holds bus_gnt until write_ack or timeout, then releases for a cycle.
module ivl_uvm_ovl_bus_window_arbiter
    import ivl_uvm_ovl_bus_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int CNT_W   = $clog2(TIMEOUT + 1),
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               write_ack,
    output logic               write,
    output logic               bus_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               done,
    output logic               timeout_err,
    output logic               stray_ack
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               write_q, write_d;
    logic               bus_gnt_q, bus_gnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               done_q, done_d;
    logic               timeout_err_q, timeout_err_d;
    logic               stray_ack_q, stray_ack_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    ivl_uvm_ovl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (req),
        .last_idx (ptr_q),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_any  (win_any)
    );

    // Outputs are computed for the state being entered, so they register with it.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        write_d       = 1'b0;
        bus_gnt_d     = bus_gnt_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        done_d        = 1'b0;
        timeout_err_d = 1'b0;
        stray_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                stray_ack_d = write_ack;
                bus_gnt_d   = 1'b0;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                if (win_any) begin
                    state_d   = START;
                    write_d   = 1'b1;
                    bus_gnt_d = 1'b1;
                    gnt_d     = win_oh;
                    gnt_idx_d = win_idx;
                end
            end
            START: begin
                stray_ack_d = write_ack;
                state_d     = WAIT_ACK;
                cnt_d       = '0;
                ptr_d       = gnt_idx_q;
            end
            WAIT_ACK: begin
                // An ack on the last allowed cycle still completes the transfer.
                if (write_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d       = RELEASE;
                    bus_gnt_d     = 1'b0;
                    gnt_d         = '0;
                    gnt_idx_d     = '0;
                    done_d        = write_ack;
                    timeout_err_d = !write_ack;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                stray_ack_d = write_ack;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            write_q       <= 1'b0;
            bus_gnt_q     <= 1'b0;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            stray_ack_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            write_q       <= write_d;
            bus_gnt_q     <= bus_gnt_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            stray_ack_q   <= stray_ack_d;
        end
    end

    assign write       = write_q;
    assign bus_gnt     = bus_gnt_q;
    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign stray_ack   = stray_ack_q;

endmodule

// File: tb/tb_ivl_uvm_ovl_bus_window_arbiter.sv
// Directed bench for the bus window arbiter: windows, round-robin order,
// timeout, stray ack and mid-window reset, plus window/one-hot monitors.
module tb_ivl_uvm_ovl_bus_window_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       write_ack;
    logic       write;
    logic       bus_gnt;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       done;
    logic       timeout_err;
    logic       stray_ack;

    int vectors;
    int miscompares;
    logic in_win;

    ivl_uvm_ovl_bus_window_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .write_ack   (write_ack),
        .write       (write),
        .bus_gnt     (bus_gnt),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .done        (done),
        .timeout_err (timeout_err),
        .stray_ack   (stray_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; ack_at = WAIT_ACK cycle carrying the ack, 0 = never.
    task automatic window(input logic [3:0] r, input int ack_at, input int exp_idx,
                          input bit drop, input string tag);
        logic [3:0] exp_oh;
        exp_oh = 4'b0001 << exp_idx;
        req = r;
        step();
        chk({tag, " start write"}, 32'(write), 32'd1);
        chk({tag, " start bus_gnt"}, 32'(bus_gnt), 32'd1);
        chk({tag, " start gnt"}, 32'(gnt), 32'(exp_oh));
        chk({tag, " start gnt_idx"}, 32'(gnt_idx), 32'(exp_idx));
        if (drop) req = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == ack_at) write_ack = 1'b1;
            chk({tag, " wait bus_gnt"}, 32'(bus_gnt), 32'd1);
            chk({tag, " wait write"}, 32'(write), 32'd0);
            if (k == ack_at) break;
        end
        step();
        write_ack = 1'b0;
        chk({tag, " release bus_gnt"}, 32'(bus_gnt), 32'd0);
        chk({tag, " release gnt"}, 32'(gnt), 32'd0);
        chk({tag, " release done"}, 32'(done), (ack_at > 0) ? 32'd1 : 32'd0);
        chk({tag, " release timeout_err"}, 32'(timeout_err), (ack_at > 0) ? 32'd0 : 32'd1);
        chk({tag, " release stray_ack"}, 32'(stray_ack), 32'd0);
        step();
        chk({tag, " idle bus_gnt"}, 32'(bus_gnt), 32'd0);
        chk({tag, " idle done"}, 32'(done), 32'd0);
        chk({tag, " idle timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Window and one-hot monitors: bus_gnt held from write through ack,
    // gnt one-hot (matching gnt_idx) exactly while bus_gnt is high.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_win = 1'b0;
        end else begin
            if (write) in_win = 1'b1;
            if (timeout_err) in_win = 1'b0;
            if (in_win) chk("window bus_gnt", 32'(bus_gnt), 32'd1);
            if (bus_gnt) begin
                chk("one_hot gnt", 32'($onehot(gnt)), 32'd1);
                chk("gnt_idx matches gnt", 32'(gnt[gnt_idx]), 32'd1);
            end else begin
                chk("gnt idle zero", 32'(gnt), 32'd0);
            end
            if (in_win && write_ack) in_win = 1'b0;
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_win      = 1'b0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        write_ack   = 1'b0;
        step();
        step();
        chk("reset write", 32'(write), 32'd0);
        chk("reset bus_gnt", 32'(bus_gnt), 32'd0);
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset gnt_idx", 32'(gnt_idx), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);
        chk("reset stray_ack", 32'(stray_ack), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle no req bus_gnt", 32'(bus_gnt), 32'd0);

        // Round robin with all requesters held: 0,1,2,3,0.
        window(4'b1111, 1, 0, 1'b0, "rr0");
        window(4'b1111, 1, 1, 1'b0, "rr1");
        window(4'b1111, 1, 2, 1'b0, "rr2");
        window(4'b1111, 1, 3, 1'b0, "rr3");
        window(4'b1111, 1, 0, 1'b0, "rr4");

        // Single requester, ack 3 cycles after write, req dropped after grant.
        window(4'b0001, 3, 0, 1'b1, "ack3");

        // Never acked: 17 bus_gnt cycles then timeout.
        window(4'b0100, 0, 2, 1'b1, "timeout");

        // Ack on the 16th WAIT_ACK cycle wins over the timeout.
        window(4'b1000, 16, 3, 1'b0, "ack16");

        // Mixed requests after winner 3: pointer wraps to 0 then skips to 2.
        window(4'b0101, 2, 0, 1'b0, "wrap0");
        window(4'b0101, 2, 2, 1'b0, "skip2");

        // Stray ack while idle.
        req = 4'b0000;
        write_ack = 1'b1;
        step();
        write_ack = 1'b0;
        chk("stray stray_ack", 32'(stray_ack), 32'd1);
        chk("stray bus_gnt", 32'(bus_gnt), 32'd0);
        chk("stray write", 32'(write), 32'd0);
        chk("stray gnt", 32'(gnt), 32'd0);
        step();
        chk("stray clears", 32'(stray_ack), 32'd0);

        // Reset in the middle of WAIT_ACK.
        req = 4'b0010;
        step();
        chk("prereset write", 32'(write), 32'd1);
        chk("prereset gnt", 32'(gnt), 32'b0010);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async bus_gnt", 32'(bus_gnt), 32'd0);
        chk("async write", 32'(write), 32'd0);
        chk("async gnt", 32'(gnt), 32'd0);
        step();
        step();
        chk("reset hold done", 32'(done), 32'd0);
        chk("reset hold timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        window(4'b0010, 2, 1, 1'b0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
